instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum WAIT cycles allowed before a timeout fault; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous, active-low.
REQ-004 pc  input  32  current program counter from the PC register stage; stable while pc_en=0.
REQ-005 pc_en  output  1  advance strobe to the PC register stage; 1 for exactly one cycle per consumed instruction.
REQ-006 mem_req_valid  output  1  instruction-memory request valid.
REQ-007 mem_req_ready  input  1  memory accepts the request when high together with mem_req_valid.
REQ-008 mem_req_addr  output  32  request address, equal to pc.
REQ-009 mem_rsp_valid  input  1  response word present.
REQ-010 mem_rsp_data  input  32  instruction word.
REQ-011 mem_rsp_err  input  1  bus error qualifier for mem_rsp_valid.
REQ-012 instr_valid  output  1  instruction available to decode.
REQ-013 instr  output  32  fetched instruction, registered.
REQ-014 instr_pc  output  32  address of instr, registered.
REQ-015 dec_ready  input  1  decode/execute consumes instr when high together with instr_valid.
REQ-016 fault  output  1  sticky fault flag.
REQ-017 fault_code  output  2  01 misaligned, 10 bus error, 11 timeout, 00 none.
REQ-018 fault_pc  output  32  pc at which the fault occurred.

Function
REQ-019 The FSM SHALL have exactly four states: REQ, WAIT, HOLD and FAULT.
REQ-020 REQ: if pc[1:0]!=0, the block SHALL keep mem_req_valid=0 and enter FAULT with code 01; otherwise it SHALL hold mem_req_valid=1 with mem_req_addr=pc.
REQ-021 REQ SHALL move to WAIT on the edge where mem_req_valid and mem_req_ready are both 1; the timeout counter SHALL clear to 0 on that edge.
REQ-022 WAIT on mem_rsp_valid=1 with mem_rsp_err=0 SHALL latch mem_rsp_data into instr and pc into instr_pc, then enter HOLD.
REQ-023 Latency: instr_valid SHALL rise in the cycle after the cycle in which the response is present.
REQ-024 WAIT on mem_rsp_valid=1 with mem_rsp_err=1 SHALL enter FAULT with code 10.
REQ-025 WAIT without a response SHALL increment the 8-bit timeout counter each cycle.
REQ-026 When the counter equals TIMEOUT-1 and no response is present, the block SHALL enter FAULT with code 11.
REQ-027 A response arriving in the same cycle as the timeout limit SHALL win: it is taken as a normal response or as a bus error.
REQ-028 HOLD: instr_valid SHALL be 1, and instr and instr_pc SHALL remain stable until consumed.
REQ-029 pc_en SHALL equal (state==HOLD) AND dec_ready, combinationally, so the PC register updates on the same edge.
REQ-030 On that same edge, HOLD SHALL return to REQ.
REQ-031 mem_rsp_valid in REQ, HOLD or FAULT SHALL be ignored, with no state change.
REQ-032 FAULT is terminal until reset.
REQ-033 In FAULT, fault SHALL be 1, pc_en, mem_req_valid and instr_valid SHALL be 0, and fault_code and fault_pc SHALL be frozen.
REQ-034 At most one request SHALL be outstanding at any time.
REQ-035 Minimum issue interval SHALL be 3 cycles per instruction: REQ, WAIT and HOLD, each one cycle.

Reset
REQ-036 While rst_n=0, the state SHALL be REQ.
REQ-037 While rst_n=0, instr, instr_pc, fault_pc, the timeout counter and fault_code SHALL all be 0.
REQ-038 While rst_n=0, fault, instr_valid, mem_req_valid and pc_en SHALL all be 0; mem_req_valid and pc_en SHALL be forced low during reset.
REQ-039 Reset asserted mid-WAIT SHALL abandon the outstanding request.
REQ-040 After the reset from REQ-039, the block SHALL re-issue from pc, with no stale response accepted until the new request handshake.

Structure
REQ-041 State encodings, fault codes and the default TIMEOUT SHALL live in the shared core package fetch_pkg.
REQ-042 One sub-module fetch_timeout SHALL hold the WAIT counter, with clear, enable and expired ports; all other logic SHALL sit in instr_fetch.

Verification
REQ-043 Misaligned fetch: reset, pc=0x00000002 -> mem_req_valid never 1; next cycle fault=1, fault_code=01, fault_pc=0x00000002.
REQ-044 Normal fetch: pc=0x00000000, ready=1, response 0x00500093 one cycle later, dec_ready=1 -> instr=0x00500093, instr_pc=0; pc_en high for exactly one cycle; next request addr equals the new pc, e.g. 0x00000004.
REQ-045 Decode stall: dec_ready=0 for 5 cycles in HOLD -> instr_valid=1 stable, instr unchanged, pc_en=0, no new request.
REQ-046 Timeout: TIMEOUT=4, no response -> after 4 WAIT cycles fault=1, fault_code=11; a late mem_rsp_valid is ignored.
REQ-047 Bus error: response with err=1 at pc=0x00000010 -> fault_code=10, fault_pc=0x00000010, pc_en stays 0.
REQ-048 Reset in WAIT: deassert rst_n while WAIT is pending -> all outputs 0 immediately; after release, a new request is issued at the current pc.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-core definitions: FSM state encodings, fault codes and the
// default WAIT timeout used by the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_BUS      = 2'b10,
    FC_TIMEOUT  = 2'b11
  } fault_code_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int TCNT_W          = 8;

endpackage

// File: rtl/fetch_timeout.sv
// WAIT-state cycle counter. Cleared when a request is accepted, advanced on
// every WAIT cycle with no response; expired flags the last allowed cycle.
module fetch_timeout
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TCNT_W-1:0] LIMIT = TCNT_W'(TIMEOUT - 1);

  logic [TCNT_W-1:0] cnt;

  // Counter: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one aligned request per instruction, holds
// the returned word for decode, and parks in a sticky FAULT state on a
// misaligned pc, a bus error or a response timeout.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        dec_ready,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_pc
);

  fetch_state_e state;
  fault_code_e  fault_code_q;
  logic         pc_aligned;
  logic         req_fire;
  logic         tmo_clear;
  logic         tmo_enable;
  logic         tmo_expired;

  assign pc_aligned = (pc[1:0] == 2'b00);

  // Request/advance strobes depend on the live pc and dec_ready, so they are
  // combinational; both are gated by rst_n so they drop the instant reset hits.
  assign mem_req_valid = rst_n && (state == ST_REQ) && pc_aligned;
  assign mem_req_addr  = pc;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign pc_en         = rst_n && (state == ST_HOLD) && dec_ready;

  assign instr_valid = (state == ST_HOLD);
  assign fault       = (state == ST_FAULT);
  assign fault_code  = fault_code_q;

  assign tmo_clear  = (state == ST_REQ) && req_fire;
  assign tmo_enable = (state == ST_WAIT) && !mem_rsp_valid;

  fetch_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Fetch FSM with the instruction and fault capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_REQ;
      instr        <= '0;
      instr_pc     <= '0;
      fault_code_q <= FC_NONE;
      fault_pc     <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (!pc_aligned) begin
            state        <= ST_FAULT;
            fault_code_q <= FC_MISALIGN;
            fault_pc     <= pc;
          end else if (req_fire) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response on the timeout-limit cycle takes precedence.
          if (mem_rsp_valid) begin
            if (mem_rsp_err) begin
              state        <= ST_FAULT;
              fault_code_q <= FC_BUS;
              fault_pc     <= pc;
            end else begin
              state    <= ST_HOLD;
              instr    <= mem_rsp_data;
              instr_pc <= pc;
            end
          end else if (tmo_expired) begin
            state        <= ST_FAULT;
            fault_code_q <= FC_TIMEOUT;
            fault_pc     <= pc;
          end
        end
        ST_HOLD: begin
          if (dec_ready) begin
            state <= ST_REQ;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (TIMEOUT=4): reset values, misaligned pc,
// normal fetch with decode stall, bus error, timeout, response on the limit
// cycle, and reset during WAIT.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_en;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .pc_en         (pc_en),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .dec_ready     (dec_ready),
    .fault         (fault),
    .fault_code    (fault_code),
    .fault_pc      (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input logic [31:0] new_pc);
    rst_n = 1'b0;
    pc = new_pc;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err = 1'b0;
    mem_rsp_data = 32'h0;
    dec_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    rst_n = 1'b0;
    pc = 32'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    mem_rsp_err = 1'b0;
    dec_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_code", 32'(fault_code), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);

    // Misaligned pc
    do_reset(32'h0000_0002);
    mem_req_ready = 1'b1;
    settle();
    chk("mis_req_valid", 32'(mem_req_valid), 32'd0);
    tick();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_code", 32'(fault_code), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h0000_0002);
    chk("mis_req_valid2", 32'(mem_req_valid), 32'd0);
    tick();
    chk("mis_sticky", 32'(fault), 32'd1);

    // Normal fetch with decode stall
    rst_n = 1'b0;
    settle();
    chk("rst_clears_fault", 32'(fault), 32'd0);
    do_reset(32'h0000_0000);
    mem_req_ready = 1'b1;
    settle();
    chk("nf_req_valid", 32'(mem_req_valid), 32'd1);
    chk("nf_req_addr", mem_req_addr, 32'h0);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h0050_0093;
    settle();
    chk("nf_wait_no_req", 32'(mem_req_valid), 32'd0);
    chk("nf_wait_no_instr", 32'(instr_valid), 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'hFFFF_FFFF;
    settle();
    chk("nf_instr_valid", 32'(instr_valid), 32'd1);
    chk("nf_instr", instr, 32'h0050_0093);
    chk("nf_instr_pc", instr_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_pc_en", 32'(pc_en), 32'd0);
      chk("stall_no_req", 32'(mem_req_valid), 32'd0);
    end
    dec_ready = 1'b1;
    settle();
    chk("nf_pc_en", 32'(pc_en), 32'd1);
    tick();
    pc = 32'h0000_0004;
    dec_ready = 1'b0;
    settle();
    chk("nf_pc_en_once", 32'(pc_en), 32'd0);
    chk("nf_back_to_req", 32'(instr_valid), 32'd0);
    chk("nf_next_req", 32'(mem_req_valid), 32'd1);
    chk("nf_next_addr", mem_req_addr, 32'h0000_0004);
    // Response in REQ is ignored
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("req_ign_rsp_req", 32'(mem_req_valid), 32'd1);
    chk("req_ign_rsp_valid", 32'(instr_valid), 32'd0);
    chk("req_ign_rsp_instr", instr, 32'h0050_0093);

    // Bus error
    do_reset(32'h0000_0010);
    mem_req_ready = 1'b1;
    dec_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_err = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err = 1'b0;
    settle();
    chk("be_fault", 32'(fault), 32'd1);
    chk("be_code", 32'(fault_code), 32'd2);
    chk("be_fault_pc", fault_pc, 32'h0000_0010);
    chk("be_pc_en", 32'(pc_en), 32'd0);
    chk("be_instr_valid", 32'(instr_valid), 32'd0);

    // Timeout
    do_reset(32'h0000_0020);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_no_fault_yet", 32'(fault), 32'd0);
    end
    tick();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_code", 32'(fault_code), 32'd3);
    chk("to_fault_pc", fault_pc, 32'h0000_0020);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("to_late_fault", 32'(fault), 32'd1);
    chk("to_late_code", 32'(fault_code), 32'd3);
    chk("to_late_valid", 32'(instr_valid), 32'd0);
    chk("to_late_instr", instr, 32'h0);

    // Response on the timeout-limit cycle wins
    do_reset(32'h0000_0024);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    tick();
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("lim_no_fault", 32'(fault), 32'd0);
    chk("lim_valid", 32'(instr_valid), 32'd1);
    chk("lim_instr", instr, 32'hDEAD_BEEF);
    chk("lim_instr_pc", instr_pc, 32'h0000_0024);

    // Reset during WAIT
    do_reset(32'h0000_0030);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h1111_2222;
    settle();
    chk("rw_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rw_pc_en", 32'(pc_en), 32'd0);
    chk("rw_instr_valid", 32'(instr_valid), 32'd0);
    chk("rw_fault", 32'(fault), 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    tick();
    chk("rw_stale_ignored", 32'(instr_valid), 32'd0);
    chk("rw_reissue", 32'(mem_req_valid), 32'd1);
    chk("rw_reissue_addr", mem_req_addr, 32'h0000_0030);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("rw_new_valid", 32'(instr_valid), 32'd1);
    chk("rw_new_instr", instr, 32'h1111_2222);
    chk("rw_new_instr_pc", instr_pc, 32'h0000_0030);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
